// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the MEM pipeline stage and
// the data RAM. Aligned halfword/word accesses go to the RAM as one native
// access. Misaligned halfword/word accesses are split into byte accesses,
// most significant byte first (big-endian), and load bytes are reassembled.
//
// Handshake: a request is taken on a rising edge where req && ready. ready is
// high in IDLE and DONE and low in ACCESS, so the requester holds req (and its
// payload) until it sees ready. done pulses for the one DONE cycle; err and
// rdata are valid with done, and rdata holds until the next completion.
module mem_access_unit #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          se,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] ram_a,
  output logic [31:0]   ram_di,
  output logic [1:0]    ram_size,
  output logic          ram_rw,
  output logic          ram_e,
  output logic          ram_se,
  input  logic [31:0]   ram_do
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  logic [1:0]    state;
  logic [1:0]    k;         // byte index within a split access
  logic          we_q;
  logic          se_q;
  logic          mis_q;     // request is being split into byte accesses
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   asm_q;     // load bytes collected so far
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic          mis_in;
  logic [1:0]    last_k;
  logic [1:0]    idx;
  logic          last_cycle;
  logic [7:0]    st_byte;
  logic [15:0]   half_val;
  logic [31:0]   mis_result;

  assign ready  = (state != S_ACCESS);
  assign accept = req && ready;
  assign done   = (state == S_DONE);
  assign err    = err_q && done;
  assign rdata  = rdata_q;

  // Decide whether the incoming request must be split into bytes
  always_comb begin
    mis_in = 1'b0;
    case (size)
      SZ_HALF: mis_in = addr[0];
      SZ_WORD: mis_in = (addr[1:0] != 2'b00);
      default: mis_in = 1'b0;
    endcase
  end

  // Byte-split bookkeeping: which byte of the value this cycle carries
  always_comb begin
    last_k     = (size_q == SZ_HALF) ? 2'd1 : 2'd3;
    idx        = last_k - k;
    last_cycle = !mis_q || (k == last_k);
    st_byte    = 8'h00;
    case (idx)
      2'd0:    st_byte = wdata_q[7:0];
      2'd1:    st_byte = wdata_q[15:8];
      2'd2:    st_byte = wdata_q[23:16];
      default: st_byte = wdata_q[31:24];
    endcase
  end

  // Final split-load result; the last byte comes straight from the RAM
  always_comb begin
    half_val   = {asm_q[15:8], ram_do[7:0]};
    mis_result = {asm_q[31:8], ram_do[7:0]};
    if (size_q == SZ_HALF) begin
      mis_result = se_q ? {{16{half_val[15]}}, half_val} : {16'h0000, half_val};
    end
  end

  // RAM port drive: active only in ACCESS, all zero otherwise
  always_comb begin
    ram_a    = '0;
    ram_di   = 32'h0;
    ram_size = 2'b00;
    ram_rw   = 1'b0;
    ram_e    = 1'b0;
    ram_se   = 1'b0;
    if (state == S_ACCESS) begin
      ram_e  = 1'b1;
      ram_rw = we_q;
      if (mis_q) begin
        ram_a    = addr_q + AW'(k);
        ram_di   = {24'h000000, st_byte};
        ram_size = SZ_BYTE;
        ram_se   = 1'b0;
      end else begin
        ram_a    = addr_q;
        ram_di   = wdata_q;
        ram_size = size_q;
        ram_se   = se_q;
      end
    end
  end

  // Sequencer FSM with request latching and load result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= 2'd0;
      we_q    <= 1'b0;
      se_q    <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            we_q    <= we;
            se_q    <= se;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            mis_q   <= mis_in;
            k       <= 2'd0;
            if (size == SZ_ILL) begin
              // Illegal size never touches the RAM
              state   <= S_DONE;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else begin
              state <= S_ACCESS;
              err_q <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (mis_q && !we_q) begin
            case (idx)
              2'd0:    asm_q[7:0]   <= ram_do[7:0];
              2'd1:    asm_q[15:8]  <= ram_do[7:0];
              2'd2:    asm_q[23:16] <= ram_do[7:0];
              default: asm_q[31:24] <= ram_do[7:0];
            endcase
          end
          if (last_cycle) begin
            state <= S_DONE;
            if (!we_q) begin
              rdata_q <= mis_q ? mis_result : ram_do;
            end
          end else begin
            k <= k + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural byte-array RAM on the ram_* port,
// plus a request-level reference (shadow memory, big-endian byte lists).
module tb_mem_access_unit;

  localparam int AW = 9;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req, we, se;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          ready, done, err;
  logic [31:0]   rdata;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_di, ram_do;
  logic [1:0]    ram_size;
  logic          ram_rw, ram_e, ram_se;

  mem_access_unit #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .se(se),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .ram_a(ram_a), .ram_di(ram_di), .ram_size(ram_size),
    .ram_rw(ram_rw), .ram_e(ram_e), .ram_se(ram_se), .ram_do(ram_do)
  );

  // behavioural data RAM (big-endian, combinational read, write on edge)
  logic [7:0] ram_mem [0:511];
  logic [7:0] ref_mem [0:511];
  logic       do_preload = 1'b1;
  logic [7:0] rb0, rb1, rb2, rb3;

  always_comb begin
    rb0 = ram_mem[ram_a];
    rb1 = ram_mem[ram_a + 9'd1];
    rb2 = ram_mem[ram_a + 9'd2];
    rb3 = ram_mem[ram_a + 9'd3];
    ram_do = 32'h0;
    case (ram_size)
      2'b00:   ram_do = ram_se ? {{24{rb0[7]}}, rb0} : {24'h0, rb0};
      2'b01:   ram_do = ram_se ? {{16{rb0[7]}}, rb0, rb1} : {16'h0, rb0, rb1};
      2'b10:   ram_do = {rb0, rb1, rb2, rb3};
      default: ram_do = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= 8'h00;
      ram_mem[9'h010] <= 8'h11; ram_mem[9'h011] <= 8'h22; ram_mem[9'h012] <= 8'h33;
      ram_mem[9'h013] <= 8'h44; ram_mem[9'h014] <= 8'h55; ram_mem[9'h015] <= 8'h66;
      ram_mem[9'h016] <= 8'h77; ram_mem[9'h017] <= 8'h88; ram_mem[9'h018] <= 8'h00;
    end else if (ram_e && ram_rw) begin
      case (ram_size)
        2'b00: ram_mem[ram_a] <= ram_di[7:0];
        2'b01: begin
          ram_mem[ram_a]        <= ram_di[15:8];
          ram_mem[ram_a + 9'd1] <= ram_di[7:0];
        end
        2'b10: begin
          ram_mem[ram_a]        <= ram_di[31:24];
          ram_mem[ram_a + 9'd1] <= ram_di[23:16];
          ram_mem[ram_a + 9'd2] <= ram_di[15:8];
          ram_mem[ram_a + 9'd3] <= ram_di[7:0];
        end
        default: ;
      endcase
    end
  end

  // scoreboard counters and checker
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: a request is an ordered list of n bytes at addr, addr+1, ...
  function automatic int ref_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic s, input logic [AW-1:0] a);
    int n;
    logic [31:0] v;
    n = ref_bytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(int'(a) + i) % 512]);
    if (s && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] d);
    int n;
    logic [31:0] sh;
    n = ref_bytes(sz);
    for (int i = 0; i < n; i++) begin
      sh = d >> (8 * (n - 1 - i));
      ref_mem[(int'(a) + i) % 512] = sh[7:0];
    end
  endtask

  // current request and expected load result
  logic          cur_we, cur_se;
  logic [1:0]    cur_size;
  logic [AW-1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [31:0]   exp_rdata = 32'h0;

  // driver: present a request and hold it until it is taken
  task automatic send(input logic w, input logic [1:0] sz, input logic s,
                      input logic [AW-1:0] a, input logic [31:0] d);
    int guard;
    req = 1'b1; we = w; size = sz; se = s; addr = a; wdata = d;
    guard = 0;
    while (!ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready_before_accept", 32'(ready), 32'd1);
    cur_we = w; cur_size = sz; cur_se = s; cur_addr = a; cur_wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  // watch the RAM port until done, check sequence, latency and result
  task automatic finish_req();
    int n, exp_n, acc, cyc;
    logic aligned, illegal;
    logic [31:0] sh;
    logic [AW-1:0] exp_a;
    illegal = (cur_size == 2'b11);
    n = ref_bytes(cur_size);
    aligned = (cur_size == 2'b00) || (cur_size == 2'b01 && !cur_addr[0]) ||
              (cur_size == 2'b10 && cur_addr[1:0] == 2'b00);
    exp_n = illegal ? 0 : (aligned ? 1 : n);
    if (illegal) exp_rdata = 32'h0;
    else if (!cur_we) exp_rdata = ref_load(cur_size, cur_se, cur_addr);
    else ref_store(cur_size, cur_addr, cur_wdata);
    acc = 0;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (done) break;
      if (ram_e) begin
        exp_a = aligned ? cur_addr : AW'((int'(cur_addr) + acc) % 512);
        check_eq("ram_a", 32'(ram_a), 32'(exp_a));
        check_eq("ram_size", 32'(ram_size), aligned ? 32'(cur_size) : 32'd0);
        check_eq("ram_rw", 32'(ram_rw), 32'(cur_we));
        check_eq("ram_se", 32'(ram_se), aligned ? 32'(cur_se) : 32'd0);
        if (cur_we) begin
          sh = cur_wdata >> (8 * (n - 1 - acc));
          check_eq("ram_di", ram_di, aligned ? cur_wdata : {24'h0, sh[7:0]});
        end
        acc++;
      end
    end
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("access_count", 32'(acc), 32'(exp_n));
    check_eq("latency", 32'(cyc), 32'(exp_n));
    check_eq("err", 32'(err), 32'(illegal));
    check_eq("rdata", rdata, exp_rdata);
    check_eq("ram_e_in_done", 32'(ram_e), 32'd0);
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic s,
                        input logic [AW-1:0] a, input logic [31:0] d);
    send(w, sz, s, a, d);
    finish_req();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_rdata"}, rdata, 32'd0);
    check_eq({tag, "_ram_e"}, 32'(ram_e), 32'd0);
    check_eq({tag, "_ram_a"}, 32'(ram_a), 32'd0);
    check_eq({tag, "_ram_di"}, ram_di, 32'd0);
    check_eq({tag, "_ram_ctl"}, {28'h0, ram_size, ram_rw, ram_se}, 32'd0);
  endtask

  // main sequence
  initial begin
    logic          rw, rs;
    logic [1:0]    rsz;
    logic [AW-1:0] ra;
    req = 1'b0; we = 1'b0; size = 2'b00; se = 1'b0; addr = '0; wdata = 32'h0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    ref_mem[9'h010] = 8'h11; ref_mem[9'h011] = 8'h22; ref_mem[9'h012] = 8'h33;
    ref_mem[9'h013] = 8'h44; ref_mem[9'h014] = 8'h55; ref_mem[9'h015] = 8'h66;
    ref_mem[9'h016] = 8'h77; ref_mem[9'h017] = 8'h88; ref_mem[9'h018] = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    do_preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // aligned word load
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    check_eq("plan_word_aligned", rdata, 32'h11223344);
    // misaligned word load
    do_req(1'b0, 2'b10, 1'b0, 9'h011, 32'h0);
    check_eq("plan_word_mis", rdata, 32'h22334455);
    // misaligned halfword, signed and unsigned
    do_req(1'b0, 2'b01, 1'b1, 9'h017, 32'h0);
    check_eq("plan_half_se", rdata, 32'hFFFF8800);
    do_req(1'b0, 2'b01, 1'b0, 9'h017, 32'h0);
    check_eq("plan_half_ze", rdata, 32'h00008800);
    // misaligned store across the top of the address space
    do_req(1'b1, 2'b10, 1'b0, 9'h1FE, 32'hAABBCCDD);
    check_eq("plan_wrap_bytes", {ram_mem[9'h1FE], ram_mem[9'h1FF], ram_mem[9'h000], ram_mem[9'h001]},
             32'hAABBCCDD);
    check_eq("plan_store_keeps_rdata", rdata, 32'h00008800);
    do_req(1'b0, 2'b10, 1'b0, 9'h000, 32'h0);
    check_eq("plan_wrap_load", rdata, 32'hCCDD0000);
    // illegal size, then a request taken in its DONE cycle
    do_req(1'b0, 2'b11, 1'b0, 9'h010, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 9'h012, 32'h0);
    check_eq("plan_after_illegal", rdata, 32'h00003344);
    // back-to-back aligned loads
    do_req(1'b0, 2'b10, 1'b0, 9'h014, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 9'h017, 32'h0);
    check_eq("plan_byte_se", rdata, 32'hFFFFFF88);

    // reset in the middle of a misaligned store
    @(negedge clk);
    send(1'b1, 2'b10, 1'b0, 9'h021, 32'h01020304);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    ref_mem[9'h021] = 8'h01;
    ref_mem[9'h022] = 8'h02;
    exp_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_bytes", {ram_mem[9'h021], ram_mem[9'h022], ram_mem[9'h023], ram_mem[9'h024]},
             32'h01020000);
    @(negedge clk);

    // randomized traffic against the reference model
    for (int t = 0; t < 80; t++) begin
      rw  = 1'($urandom_range(0, 1));
      rsz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rs  = 1'($urandom_range(0, 1));
      ra  = AW'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) ra = AW'($urandom_range(508, 511));
      if ($urandom_range(0, 2) == 0) ra[1:0] = 2'b00;
      do_req(rw, rsz, rs, ra, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // whole-memory consistency with the reference
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      if (ram_mem[i] !== ref_mem[i]) check_eq($sformatf("mem_%03h", i), 32'(ram_mem[i]), 32'(ref_mem[i]));
    end
    check_eq("mem_sample_010", 32'(ram_mem[9'h010]), 32'(ref_mem[9'h010]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store sequencer sitting directly upstream of the data RAM: accepts one load/store request at a time from the MEM pipeline stage and drives the RAM's address, data, size, read/write, enable and sign-extend inputs. Aligned halfword and word accesses go to the RAM as a single native access. Misaligned halfword and word accesses are split into sequential byte accesses, and the byte-wise load results are reassembled big-endian. It reports completion and load data back to the pipeline with a req/ready/done handshake.

## Interface
- `AW`, 9: byte-address width; must match the RAM address port.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 1: request valid; accepted on a rising edge where `req && ready`.
- `we` input 1: 1 = store, 0 = load.
- `size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `se` input 1: sign-extend load result.
- `addr` input AW: byte address.
- `wdata` input 32: store data, right-justified.
- `ready` output 1: can accept a request.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; the request had `size` = 11.
- `rdata` output 32: load result; valid with `done`; held until the next completion.
- `ram_a` output AW: RAM address.
- `ram_di` output 32: RAM write data.
- `ram_size` output 2: RAM access size.
- `ram_rw` output 1: RAM direction; 1 = write.
- `ram_e` output 1: RAM enable.
- `ram_se` output 1: RAM sign-extend select.
- `ram_do` input 32: RAM read data; combinational from the `ram_*` outputs.

## Operation
- **States:**
  - IDLE is the reset state.
  - ACCESS issues the RAM accesses.
  - DONE is the completion cycle.
- **Acceptance:**
  - `ready` = 1 in IDLE and DONE, 0 in ACCESS.
  - On acceptance, `we`, `size`, `se`, `addr` and `wdata` are latched and the state goes to ACCESS.
  - A request accepted in DONE goes directly to ACCESS.
- **Alignment:**
  - A byte access is always aligned.
  - A halfword is aligned when `addr[0]` = 0.
  - A word is aligned when `addr[1:0]` = 0.
- **Aligned access:** one ACCESS cycle with `ram_a` = addr, `ram_size` = size, `ram_se` = se, `ram_rw` = we, `ram_di` = wdata, `ram_e` = 1. For a load, `ram_do` is captured into `rdata` at the end of the cycle.
- **Misaligned access:** n = 2 (halfword) or 4 (word) ACCESS cycles, indexed by a 2-bit counter k = 0..n-1.
  - Each cycle drives `ram_a` = (addr + k) mod 2^AW, `ram_size` = 00, `ram_se` = 0, `ram_e` = 1.
  - Store: `ram_rw` = 1 and `ram_di[7:0]` = wdata[(n-1-k)*8 +: 8]. The upper `ram_di` bits are 0.
  - Load: `ram_do[7:0]` goes into assembly bits [(n-1-k)*8 +: 8].
  - After the last byte, `rdata` = the assembled value zero- or sign-extended from bit 8n-1 according to `se`.
- **Address wrap:** misaligned addresses wrap modulo 512; byte 0x1FF is followed by 0x000.
- **Illegal size:** zero ACCESS cycles with `ram_e` = 0, then DONE with `err` = 1 and `rdata` = 0. RAM contents are unchanged.
- **Store completion:** `rdata` is unchanged by a store.
- **RAM port defaults:** outside ACCESS, all `ram_*` outputs are 0.
- **Reset:**
  - During reset: state IDLE, `ready` = 1, `done` = 0, `err` = 0, `rdata` = 0, all `ram_*` = 0, counter = 0.
  - Reset during a misaligned store aborts it. Bytes already committed stay in the RAM; there is no rollback.

## Timing
- Request accepted at edge T.
- Aligned: ACCESS in cycle T..T+1, DONE in cycle T+1..T+2. `done` is high one cycle after acceptance.
- Misaligned: n ACCESS cycles, then DONE. `done` is high n cycles after acceptance.
- Illegal: DONE directly in the cycle after acceptance.
- RAM stores commit at the rising edge ending each ACCESS cycle.
- Back-to-back aligned requests give one access every 2 cycles.
- `done` is never high in two consecutive cycles unless back-to-back requests were accepted in DONE.
- `req` is ignored while `ready` = 0; the requester holds its request.

## Test plan
RAM preload: 0x010..0x018 = 11 22 33 44 55 66 77 88 00; all other locations 0.
- Aligned word load at 0x010 -> one cycle with `ram_e` = 1 and `ram_size` = 10; `done` one cycle after acceptance; `rdata` = 0x11223344.
- Misaligned word load at 0x011 -> four byte reads at 0x011..0x014; `rdata` = 0x22334455; `done` 4 cycles after acceptance.
- Misaligned halfword load at 0x017 with `se` = 1 -> bytes 88, 00 give `rdata` = 0xFFFF8800; with `se` = 0, `rdata` = 0x00008800.
- Misaligned word store 0xAABBCCDD at 0x1FE -> RAM bytes 0x1FE = AA, 0x1FF = BB, 0x000 = CC, 0x001 = DD. A following aligned load at 0x000 then returns 0xCCDD0000.
- `size` = 11 load -> `ram_e` stays 0; `done` = 1 with `err` = 1 and `rdata` = 0 one cycle after acceptance. A new request accepted in that DONE cycle completes normally.
- Assert `rst_n` = 0 after 2 cycles of a misaligned word store 0x01020304 at 0x021 -> 0x021 = 01 and 0x022 = 02; 0x023 and 0x024 remain 00. All outputs return to their reset values immediately, and `ready` = 1.
